// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared AES word-stream constants and state encodings
// Purpose: word/block sizing defaults and serializer FSM states, shared by the
//          transmit serializer and the receive-side group counter.
package aes_stream_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int WORDS_DEF  = 4;
  localparam int BLOCK_W    = WORD_W_DEF * WORDS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } ser_state_e;

endpackage

// File: rtl/aes_block_serializer_if.sv
// rtl/aes_block_serializer_if.sv - block-in / word-strobe-out bundle
// Ports: in_valid/in_block/in_ready (block handshake), out_ready (sink
//        back-pressure), o_strob/o_word/o_last (word stream), done (block end).
// Modports: master = block source and word sink side, slave = serializer.
interface aes_block_serializer_if
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int WORDS  = WORDS_DEF
);

  logic                      in_valid;
  logic [WORD_W*WORDS-1:0]   in_block;
  logic                      in_ready;
  logic                      out_ready;
  logic                      o_strob;
  logic [WORD_W-1:0]         o_word;
  logic                      o_last;
  logic                      done;

  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, o_strob, o_word, o_last, done
  );

  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, o_strob, o_word, o_last, done
  );

endinterface

// File: rtl/aes_block_serializer.sv
// rtl/aes_block_serializer.sv - serialize one AES block into strobed words
// Purpose: capture a WORD_W*WORDS block on in_valid & in_ready, emit it MSW
//          first as WORDS strobed words (stalled by out_ready), then pulse done.
// Ports: clk, reset (sync, active high), bus (aes_block_serializer_if.slave).
module aes_block_serializer
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  aes_block_serializer_if.slave  bus
);

  localparam int BW    = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  ser_state_e         state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [BW-1:0]      shreg;
  logic               idx_last;
  logic               capture;

  assign idx_last = (idx == IDX_W'(WORDS - 1));

  // DONE also accepts a new block so that the done pulse and the next capture
  // share an edge; that is what gives the 5-cycle minimum block period.
  assign bus.in_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign capture      = bus.in_valid && bus.in_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (capture) state_next = ST_SEND;
      ST_SEND: if (bus.out_ready && idx_last) state_next = ST_DONE;
      ST_DONE: state_next = capture ? ST_SEND : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      shreg       <= '0;
      bus.o_strob <= 1'b0;
      bus.o_last  <= 1'b0;
      bus.o_word  <= '0;
      bus.done    <= 1'b0;
    end else begin
      bus.o_strob <= 1'b0;
      bus.o_last  <= 1'b0;
      bus.done    <= (state == ST_DONE);
      if (capture) begin
        shreg <= bus.in_block;
        idx   <= '0;
      end else if (state == ST_SEND && bus.out_ready) begin
        // The next word to send always sits in the top slot of shreg.
        bus.o_strob <= 1'b1;
        bus.o_word  <= shreg[BW-1 -: WORD_W];
        bus.o_last  <= idx_last;
        shreg       <= shreg << WORD_W;
        idx         <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
// tb/tb_aes_block_serializer.sv - self-checking bench for aes_block_serializer
module tb_aes_block_serializer;
  import aes_stream_pkg::*;

  typedef struct {
    logic        cap;
    logic        ordy;
    logic        s;
    logic [31:0] w;
    logic        l;
    logic        d;
    logic        r;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_block_serializer_if bus ();

  aes_block_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic cap, logic ordy, logic s, logic [31:0] w,
                              logic l, logic d, logic r);
    vec_t v;
    v.cap = cap; v.ordy = ordy; v.s = s; v.w = w; v.l = l; v.d = d; v.r = r;
    return v;
  endfunction

  vec_t        vt[15];
  logic [127:0] blk, blk_a, blk_b;
  logic [31:0]  exp_w[$];
  logic [31:0]  got_w[$];

  initial begin
    int ncap, nd, nlow, k, grp, scnt, cyc;
    int cap_e[4];
    logic rdy, cap;

    blk   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blk_a = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    blk_b = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    // Basic block: capture row, then edges N+1..N+5.
    vt[0]  = mk(1, 1, 0, 32'h00000000, 0, 0, 0);
    vt[1]  = mk(0, 1, 1, 32'h00112233, 0, 0, 0);
    vt[2]  = mk(0, 1, 1, 32'h44556677, 0, 0, 0);
    vt[3]  = mk(0, 1, 1, 32'h8899AABB, 0, 0, 0);
    vt[4]  = mk(0, 1, 1, 32'hCCDDEEFF, 1, 0, 1);
    vt[5]  = mk(0, 1, 0, 32'hCCDDEEFF, 0, 1, 1);
    // Stall: out_ready low at N+2 and N+3.
    vt[6]  = mk(1, 1, 0, 32'hCCDDEEFF, 0, 0, 0);
    vt[7]  = mk(0, 1, 1, 32'h00112233, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 32'h00112233, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 32'h00112233, 0, 0, 0);
    vt[10] = mk(0, 1, 1, 32'h44556677, 0, 0, 0);
    vt[11] = mk(0, 1, 1, 32'h8899AABB, 0, 0, 0);
    vt[12] = mk(0, 1, 1, 32'hCCDDEEFF, 1, 0, 1);
    vt[13] = mk(0, 1, 0, 32'hCCDDEEFF, 0, 1, 1);
    vt[14] = mk(0, 1, 0, 32'hCCDDEEFF, 0, 0, 1);

    // Reset state.
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("reset o_strob", bus.o_strob, 0);
    chk("reset o_word", bus.o_word, 0);
    chk("reset o_last", bus.o_last, 0);
    chk("reset done", bus.done, 0);
    chk("reset in_ready", bus.in_ready, 1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      bus.in_valid  = vt[i].cap;
      bus.in_block  = blk;
      bus.out_ready = vt[i].ordy;
      tick();
      chk($sformatf("row%0d o_strob", i), bus.o_strob, vt[i].s);
      chk($sformatf("row%0d o_word", i), bus.o_word, vt[i].w);
      chk($sformatf("row%0d o_last", i), bus.o_last, vt[i].l);
      chk($sformatf("row%0d done", i), bus.done, vt[i].d);
      chk($sformatf("row%0d in_ready", i), bus.in_ready, vt[i].r);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Back-to-back: in_valid held high with two blocks.
    for (int i = 0; i < 4; i++) exp_w.push_back(blk_a[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) exp_w.push_back(blk_b[127-32*i -: 32]);
    got_w.delete();
    ncap = 0; nd = 0; nlow = 0;
    bus.in_valid = 1'b1;
    bus.in_block = blk_a;
    for (int e = 0; e < 14; e++) begin
      rdy = bus.in_ready;
      cap = bus.in_valid & rdy;
      tick();
      if (cap && ncap < 4) begin cap_e[ncap] = e; ncap++; end
      if (ncap == 1) bus.in_block = blk_b;
      if (ncap >= 2) bus.in_valid = 1'b0;
      if (bus.o_strob) got_w.push_back(bus.o_word);
      if (bus.done) nd++;
      if (!bus.in_ready) nlow++;
    end
    chk("b2b captures", ncap, 2);
    if (ncap == 2) begin
      chk("b2b first capture edge", cap_e[0], 0);
      chk("b2b second capture edge", cap_e[1], 5);
    end
    chk("b2b strobes", got_w.size(), 8);
    for (int i = 0; i < 8 && i < got_w.size(); i++)
      chk($sformatf("b2b word%0d", i), got_w[i], exp_w[i]);
    chk("b2b done pulses", nd, 2);
    chk("b2b in_ready low cycles", nlow, 8);

    // Reset mid-block, including reset colliding with in_valid.
    bus.in_valid = 1'b1;
    bus.in_block = blk_a;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rst pre word0", bus.o_word, 32'h01020304);
    reset = 1'b1;
    tick();
    chk("rst o_strob", bus.o_strob, 0);
    chk("rst o_word", bus.o_word, 0);
    chk("rst o_last", bus.o_last, 0);
    chk("rst done", bus.done, 0);
    chk("rst in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("rst+valid no capture strob", bus.o_strob, 0);
    chk("rst+valid no done", bus.done, 0);
    chk("rst+valid in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_block = blk_b;
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      tick();
      if (bus.o_strob) begin
        chk($sformatf("rst new word%0d", k), bus.o_word, blk_b[127-32*k -: 32]);
        k++;
      end
    end
    chk("rst new word count", k, 4);
    tick();
    chk("rst new done", bus.done, 1);

    // Loopback into a group counter model with random back-pressure.
    ncap = 0; nd = 0; grp = 0; scnt = 0; cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_block = blk;
    while (nd < 3 && cyc < 200) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      rdy = bus.in_ready;
      cap = bus.in_valid & rdy;
      tick();
      cyc++;
      if (cap) ncap++;
      if (ncap >= 3) bus.in_valid = 1'b0;
      if (bus.o_strob) begin
        scnt++;
        if (scnt == WORDS_DEF) begin grp++; scnt = 0; end
      end
      if (bus.done) nd++;
    end
    chk("loop within cycle budget", (cyc < 200), 1);
    chk("loop groups", grp, 3);
    chk("loop done pulses", nd, 3);
    chk("loop leftover strobes", scnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_block_serializer.md
# aes_block_serializer

Transmit side of the AES word-strobe interface. Accepts a 128-bit AES block over a valid/ready handshake and emits it as four 32-bit words, each marked by a one-cycle `o_strob`. After the last word it issues a one-cycle `done` pulse. It sits between the cipher core output and the downstream word sink, and produces exactly the strobe groups the group-counting logic consumes.

## Interface
- `WORD_W`, default 32: width of one output word.
- `WORDS`, default 4: words per block. Block width is `WORD_W*WORDS`.
- `clk`  input  1  single clock; everything is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_block` holds a block to send.
- `in_block`  input  WORD_W*WORDS  block to serialize; bit 127 is the MSB.
- `in_ready`  output  1  block accepted at an edge where `in_valid & in_ready`.
- `out_ready`  input  1  sink can take a word this cycle.
- `o_strob`  output  1  one-cycle strobe; `o_word` is valid in that cycle.
- `o_word`  output  WORD_W  current output word.
- `o_last`  output  1  high together with `o_strob` on the final word of a block.
- `done`  output  1  one-cycle pulse after the final word of a block.

## Operation
- The FSM has three states: IDLE, SEND and DONE.
- **IDLE**
  - `in_ready` is 1, decoded combinationally from the state.
  - On `in_valid & in_ready`: latch `in_block` into the shift register, clear `idx`, go to SEND.
- **SEND**
  - `in_ready` is 0 and `in_valid` is ignored.
  - Each edge with `out_ready`=1:
    - `o_strob`<=1.
    - `o_word`<=word `idx`. Word 0 is `in_block[127:96]`, so the most significant word goes first.
    - `o_last`<=(`idx`==WORDS-1).
    - `idx`++.
  - Each edge with `out_ready`=0: `o_strob`<=0 and `o_last`<=0; `idx` and `o_word` hold.
  - After the word with `idx`==WORDS-1 is emitted, go to DONE.
- **DONE**
  - On the next edge: `done`<=1, `o_strob`<=0, go to IDLE.
  - `done` is high for exactly one cycle.
- **Word counter `idx`**
  - Width is $clog2(WORDS).
  - It wraps to 0 naturally when WORDS is a power of two; it is cleared on capture in any case.
- **Outputs**
  - `o_strob`, `o_last`, `o_word` and `done` are registered.
  - `o_word` holds its last value when `o_strob`=0.
- **Reset values**
  - State IDLE, `idx`=0, `o_strob`=0, `o_last`=0, `o_word`=0, `done`=0.
  - The shift register is cleared to 0.
- **Reset mid-block**
  - The block in progress is discarded.
  - No `done` pulse is generated.
  - `in_ready` is 1 in the cycle after reset deasserts.
- **Simultaneous `reset` and `in_valid`**: reset wins and nothing is captured.

## Timing
- Block captured at edge N, with `out_ready` held at 1:
  - Words appear at edges N+1 to N+4.
  - `o_last` is high at edge N+4.
  - `done` is high at edge N+5.
  - `in_ready` is 1 again from edge N+5.
  - The next capture is no earlier than edge N+5.
- Minimum block period is 5 cycles.
- Each cycle of `out_ready`=0 during SEND adds exactly one cycle of latency.
- Strobes within a block are back-to-back unless stalled.
- `o_strob` is never high for two blocks without a `done` pulse between them.

## Structure
- Shared package `aes_stream_pkg` holds:
  - The `WORD_W` and `WORDS` defaults.
  - The block width constant.
  - The IDLE/SEND/DONE state encodings.
  - Both this block and the receive-side group counter import it.
- A single module is sufficient: FSM, `idx` counter and shift-register mux, with no sub-module.
- Shift-register implementation: shift left by `WORD_W` per emitted word and output the top word, rather than a wide mux on `idx`.

## Test plan
- **Basic block**
  - Stimulus: `in_block`=128'h00112233_44556677_8899AABB_CCDDEEFF, `out_ready`=1.
  - Response: `o_word` = 00112233, 44556677, 8899AABB, CCDDEEFF at edges N+1 to N+4.
  - `o_last` only at N+4; `done` at N+5.
- **Stall**
  - Stimulus: same block, `out_ready`=0 at edges N+2 and N+3.
  - Response: strobes at N+1, N+4, N+5, N+6; `done` at N+7; `o_word` is unchanged during the stall.
- **Back-to-back**
  - Stimulus: `in_valid` held at 1 with two distinct blocks.
  - Response: the second capture happens at N+5; exactly 8 strobes; 2 `done` pulses; `in_ready`=0 throughout SEND.
- **Reset mid-block**
  - Stimulus: `reset` asserted at edge N+2.
  - Response: all outputs are 0 at the next edge, no `done`, `in_ready`=1.
  - A new block then serializes correctly from word 0.
- **Loopback**
  - Stimulus: connect `o_strob` to the receive-side group counter and send 3 blocks.
  - Response: the counter's group pulse count matches `done` pulses, 3 each.
